// File: rtl/dbus_ram_wbuf.sv
// Posted-write buffer between the dbus RAM port and SRAM controller port 2.
// Optional store-to-load forwarding is enabled by defining DBUS_WBUF_FORWARD_EN.
module dbus_ram_wbuf #(
  parameter int DEPTH = 4,
  parameter int AW    = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] up_address,
  input  logic [31:0]   up_data_i,
  input  logic [3:0]    up_data_enable,
  input  logic          up_rd,
  input  logic          up_wr,
  output logic [31:0]   up_data_o,
  output logic          up_stall,
  output logic [AW-1:0] ram_address,
  output logic [31:0]   ram_data_i,
  output logic [3:0]    ram_data_enable,
  output logic          ram_rd,
  output logic          ram_wr,
  input  logic [31:0]   ram_data_o,
  input  logic          ram_stall,
  output logic          wbuf_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ} state_t;

  state_t          state_q;
  logic [PW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-3:0]   fa_q [DEPTH];
  logic [31:0]     fd_q [DEPTH];
  logic [3:0]      fe_q [DEPTH];

  logic [AW-3:0]   ram_addr_q;
  logic [31:0]     ram_data_q;
  logic [3:0]      ram_be_q;
  logic            ram_rd_q, ram_wr_q;

  logic            push, pop, full;
  logic            fwd_hit;
  logic [31:0]     fwd_data;

  logic [PW-1:0]   hidx;
  logic            use_fifo;
  logic [AW-3:0]   h_addr;
  logic [31:0]     h_data;
  logic [3:0]      h_be;

  logic            unused_addr_lsb;
  assign unused_addr_lsb = ^up_address[1:0];

  assign full = (count_q == CW'(DEPTH));
  assign pop  = (state_q == S_WRITE) && !ram_stall;
  assign push = up_wr && (!full || pop);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

`ifdef DBUS_WBUF_FORWARD_EN
  // Later (younger) entries overwrite earlier matches, so the youngest wins.
  always_comb begin
    logic          match;
    logic [3:0]    match_be;
    logic [PW-1:0] idx;
    match    = 1'b0;
    match_be = 4'h0;
    fwd_data = 32'h0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + PW'(i);
      if ((CW'(i) < count_q) && (fa_q[idx] == up_address[AW-1:2])) begin
        match    = 1'b1;
        match_be = fe_q[idx];
        fwd_data = fd_q[idx];
      end
    end
    fwd_hit = up_rd && !up_wr && match && (match_be == 4'hF);
  end
`else
  assign fwd_hit  = 1'b0;
  assign fwd_data = 32'h0;
`endif

  // Next entry to present on the SRAM port; a push into an otherwise
  // drained buffer is taken straight from the bus.
  always_comb begin
    hidx     = rptr_q;
    use_fifo = (count_q != '0);
    if (state_q == S_WRITE) begin
      hidx     = rptr_q + PW'(1);
      use_fifo = (count_q > CW'(1));
    end
    h_addr = use_fifo ? fa_q[hidx] : up_address[AW-1:2];
    h_data = use_fifo ? fd_q[hidx] : up_data_i;
    h_be   = use_fifo ? fe_q[hidx] : up_data_enable;
  end

  always_comb begin
    up_stall = 1'b0;
    if (up_wr) begin
      up_stall = !push;
    end else if (up_rd) begin
      if (fwd_hit)                  up_stall = 1'b0;
      else if (state_q == S_READ)   up_stall = ram_stall;
      else                          up_stall = 1'b1;
    end
  end

  always_comb begin
    up_data_o = 32'h0;
    if (fwd_hit)                up_data_o = fwd_data;
    else if (state_q == S_READ) up_data_o = ram_data_o;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fa_q[wptr_q] <= up_address[AW-1:2];
      fd_q[wptr_q] <= up_data_i;
      fe_q[wptr_q] <= up_data_enable;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      ram_addr_q <= '0;
      ram_data_q <= 32'h0;
      ram_be_q   <= 4'h0;
      ram_rd_q   <= 1'b0;
      ram_wr_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      case (state_q)
        S_IDLE: begin
          if ((count_q != '0) || push) begin
            state_q    <= S_WRITE;
            ram_wr_q   <= 1'b1;
            ram_addr_q <= h_addr;
            ram_data_q <= h_data;
            ram_be_q   <= h_be;
          end else if (up_rd && !fwd_hit) begin
            state_q    <= S_READ;
            ram_rd_q   <= 1'b1;
            ram_addr_q <= up_address[AW-1:2];
            ram_be_q   <= up_data_enable;
          end
        end
        S_WRITE: begin
          if (!ram_stall) begin
            if (count_d != '0) begin
              ram_addr_q <= h_addr;
              ram_data_q <= h_data;
              ram_be_q   <= h_be;
            end else begin
              state_q  <= S_IDLE;
              ram_wr_q <= 1'b0;
            end
          end
        end
        S_READ: begin
          if (!ram_stall) begin
            state_q  <= S_IDLE;
            ram_rd_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          ram_rd_q <= 1'b0;
          ram_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign ram_address     = {ram_addr_q, 2'b00};
  assign ram_data_i      = ram_data_q;
  assign ram_data_enable = ram_be_q;
  assign ram_rd          = ram_rd_q;
  assign ram_wr          = ram_wr_q;
  assign wbuf_empty      = (count_q == '0) && (state_q == S_IDLE);

endmodule

// File: tb/tb_dbus_ram_wbuf.sv
// Directed bench for dbus_ram_wbuf with a byte-enable SRAM model and write log.
// Forwarding scenarios are compiled when DBUS_WBUF_FORWARD_EN is defined.
module tb_dbus_ram_wbuf;
  localparam int DEPTH = 4;
  localparam int AW    = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] up_address;
  logic [31:0]   up_data_i;
  logic [3:0]    up_data_enable;
  logic          up_rd, up_wr;
  logic [31:0]   up_data_o;
  logic          up_stall;
  logic [AW-1:0] ram_address;
  logic [31:0]   ram_data_i;
  logic [3:0]    ram_data_enable;
  logic          ram_rd, ram_wr;
  logic [31:0]   ram_data_o;
  logic          ram_stall;
  logic          wbuf_empty;

  int checks = 0;
  int errors = 0;

  logic [31:0]   mem [1024];
  logic [AW-1:0] wlog_a [$];
  logic [31:0]   wlog_d [$];
  int            rd_cnt = 0;
  int            occ = 0;
  logic          occ_err = 1'b0;

  dbus_ram_wbuf #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_address(up_address), .up_data_i(up_data_i), .up_data_enable(up_data_enable),
    .up_rd(up_rd), .up_wr(up_wr), .up_data_o(up_data_o), .up_stall(up_stall),
    .ram_address(ram_address), .ram_data_i(ram_data_i), .ram_data_enable(ram_data_enable),
    .ram_rd(ram_rd), .ram_wr(ram_wr), .ram_data_o(ram_data_o), .ram_stall(ram_stall),
    .wbuf_empty(wbuf_empty)
  );

  always #5 clk = ~clk;

  assign ram_data_o = mem[ram_address[11:2]];

  // SRAM model: a write completes on any edge where ram_wr is high and ram_stall low.
  always @(posedge clk) begin
    if (rst_n && ram_wr && !ram_stall) begin
      wlog_a.push_back(ram_address);
      wlog_d.push_back(ram_data_i);
      for (int b = 0; b < 4; b++)
        if (ram_data_enable[b]) mem[ram_address[11:2]][8*b +: 8] <= ram_data_i[8*b +: 8];
    end
    if (rst_n && ram_rd) rd_cnt <= rd_cnt + 1;
    if (!rst_n) occ <= 0;
    else occ <= occ + ((up_wr && !up_stall) ? 1 : 0) - ((ram_wr && !ram_stall) ? 1 : 0);
    if (occ > DEPTH) occ_err <= 1'b1;
  end

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL reset_ram_rd got %b exp 0", ram_rd); end
    checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL reset_ram_wr got %b exp 0", ram_wr); end
    checks++; if (ram_address !== 24'h0) begin errors++; $display("FAIL reset_ram_address got %h exp 0", ram_address); end
    checks++; if (ram_data_i !== 32'h0) begin errors++; $display("FAIL reset_ram_data_i got %h exp 0", ram_data_i); end
    checks++; if (ram_data_enable !== 4'h0) begin errors++; $display("FAIL reset_ram_be got %h exp 0", ram_data_enable); end
    checks++; if (up_data_o !== 32'h0) begin errors++; $display("FAIL reset_up_data_o got %h exp 0", up_data_o); end
    checks++; if (up_stall !== 1'b0) begin errors++; $display("FAIL reset_up_stall got %b exp 0", up_stall); end
    checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL reset_wbuf_empty got %b exp 1", wbuf_empty); end
  endtask

  task automatic test_single_store;
    int base;
    base = wlog_a.size();
    ram_stall = 1'b0;
    up_wr = 1'b1; up_address = 24'h000100; up_data_i = 32'hDEADBEEF; up_data_enable = 4'hF;
    @(negedge clk);
    checks++; if (up_stall !== 1'b0) begin errors++; $display("FAIL single_up_stall got %b exp 0", up_stall); end
    cyc();
    up_wr = 1'b0;
    @(negedge clk);
    checks++; if (ram_wr !== 1'b1) begin errors++; $display("FAIL single_ram_wr got %b exp 1", ram_wr); end
    checks++; if (ram_address !== 24'h000100) begin errors++; $display("FAIL single_ram_address got %h exp 000100", ram_address); end
    checks++; if (ram_data_i !== 32'hDEADBEEF) begin errors++; $display("FAIL single_ram_data got %h exp deadbeef", ram_data_i); end
    checks++; if (wbuf_empty !== 1'b0) begin errors++; $display("FAIL single_busy_empty got %b exp 0", wbuf_empty); end
    cyc();
    @(negedge clk);
    checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL single_ram_wr_done got %b exp 0", ram_wr); end
    checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL single_wbuf_empty got %b exp 1", wbuf_empty); end
    checks++; if (wlog_a.size() !== base + 1) begin errors++; $display("FAIL single_write_count got %0d exp %0d", wlog_a.size(), base + 1); end
    cyc();
  endtask

  task automatic test_load_empty;
    ram_stall = 1'b1;
    up_rd = 1'b1; up_address = 24'h000100; up_data_enable = 4'hF;
    @(negedge clk);
    checks++; if (up_stall !== 1'b1) begin errors++; $display("FAIL lde_stall0 got %b exp 1", up_stall); end
    checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL lde_ram_rd0 got %b exp 0", ram_rd); end
    cyc();
    @(negedge clk);
    checks++; if (ram_rd !== 1'b1) begin errors++; $display("FAIL lde_ram_rd1 got %b exp 1", ram_rd); end
    checks++; if (up_stall !== 1'b1) begin errors++; $display("FAIL lde_stall1 got %b exp 1", up_stall); end
    checks++; if (ram_address !== 24'h000100) begin errors++; $display("FAIL lde_ram_address got %h exp 000100", ram_address); end
    cyc();
    ram_stall = 1'b0;
    @(negedge clk);
    checks++; if (up_stall !== 1'b0) begin errors++; $display("FAIL lde_stall2 got %b exp 0", up_stall); end
    checks++; if (up_data_o !== 32'hDEADBEEF) begin errors++; $display("FAIL lde_data got %h exp deadbeef", up_data_o); end
    cyc();
    up_rd = 1'b0;
    @(negedge clk);
    checks++; if (ram_rd !== 1'b0) begin errors++; $display("FAIL lde_ram_rd_end got %b exp 0", ram_rd); end
    cyc();
  endtask

  task automatic test_full;
    int base, n;
    base = wlog_a.size();
    ram_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      up_wr = 1'b1; up_address = 24'h000200 + 24'(4 * k); up_data_i = 32'(k + 1); up_data_enable = 4'hF;
      @(negedge clk);
      checks++; if (up_stall !== 1'b0) begin errors++; $display("FAIL full_accept%0d got %b exp 0", k, up_stall); end
      cyc();
    end
    up_address = 24'h000210; up_data_i = 32'd5;
    repeat (2) begin
      @(negedge clk);
      checks++; if (up_stall !== 1'b1) begin errors++; $display("FAIL full_stall got %b exp 1", up_stall); end
      cyc();
    end
    ram_stall = 1'b0;
    @(negedge clk);
    checks++; if (up_stall !== 1'b0) begin errors++; $display("FAIL full_pop_accept got %b exp 0", up_stall); end
    cyc();
    up_wr = 1'b0;
    n = 0;
    @(negedge clk);
    while (!wbuf_empty && n < 40) begin @(negedge clk); n++; end
    checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL full_drain_timeout got %b exp 1", wbuf_empty); end
    checks++;
    if (wlog_a.size() !== base + 5) begin
      errors++; $display("FAIL full_write_count got %0d exp %0d", wlog_a.size(), base + 5);
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (wlog_a[base+i] !== 24'h000200 + 24'(4 * i) || wlog_d[base+i] !== 32'(i + 1)) begin
          errors++; $display("FAIL full_order%0d got %h/%h exp %h/%h", i, wlog_a[base+i], wlog_d[base+i],
                             24'h000200 + 24'(4 * i), 32'(i + 1));
        end
      end
    end
    cyc();
  endtask

`ifndef DBUS_WBUF_FORWARD_EN
  task automatic test_load_after_store;
    ram_stall = 1'b0;
    up_wr = 1'b1; up_address = 24'h000040; up_data_i = 32'h11223344; up_data_enable = 4'hF;
    @(negedge clk);
    checks++; if (up_stall !== 1'b0) begin errors++; $display("FAIL las_store_stall got %b exp 0", up_stall); end
    cyc();
    up_wr = 1'b0; up_rd = 1'b1;
    @(negedge clk);
    checks++; if (up_stall !== 1'b1 || ram_rd !== 1'b0 || ram_wr !== 1'b1) begin
      errors++; $display("FAIL las_c1 got stall=%b rd=%b wr=%b exp 1/0/1", up_stall, ram_rd, ram_wr); end
    cyc();
    @(negedge clk);
    checks++; if (up_stall !== 1'b1 || ram_rd !== 1'b0) begin
      errors++; $display("FAIL las_c2 got stall=%b rd=%b exp 1/0", up_stall, ram_rd); end
    cyc();
    @(negedge clk);
    checks++; if (ram_rd !== 1'b1 || up_stall !== 1'b0) begin
      errors++; $display("FAIL las_c3 got rd=%b stall=%b exp 1/0", ram_rd, up_stall); end
    checks++; if (up_data_o !== 32'h11223344) begin errors++; $display("FAIL las_data got %h exp 11223344", up_data_o); end
    checks++; if (ram_address !== 24'h000040) begin errors++; $display("FAIL las_address got %h exp 000040", ram_address); end
    cyc();
    up_rd = 1'b0;
    cyc();
  endtask
`endif

`ifdef DBUS_WBUF_FORWARD_EN
  task automatic test_forward;
    int rdb, n;
    rdb = rd_cnt;
    ram_stall = 1'b1;
    up_wr = 1'b1; up_address = 24'h000080; up_data_i = 32'h0000000A; up_data_enable = 4'hF;
    cyc();
    up_data_i = 32'h0000000B;
    cyc();
    up_wr = 1'b0; up_rd = 1'b1;
    @(negedge clk);
    checks++; if (up_stall !== 1'b0) begin errors++; $display("FAIL fwd_stall got %b exp 0", up_stall); end
    checks++; if (up_data_o !== 32'h0000000B) begin errors++; $display("FAIL fwd_data got %h exp 0000000b", up_data_o); end
    cyc();
    up_rd = 1'b0;
    up_wr = 1'b1; up_address = 24'h000084; up_data_i = 32'h99887766; up_data_enable = 4'hF;
    cyc();
    up_data_i = 32'h00005555; up_data_enable = 4'h3;
    cyc();
    up_wr = 1'b0; up_rd = 1'b1; up_data_enable = 4'hF;
    @(negedge clk);
    checks++; if (up_stall !== 1'b1) begin errors++; $display("FAIL fwd_partial_stall got %b exp 1", up_stall); end
    checks++; if (rd_cnt !== rdb) begin errors++; $display("FAIL fwd_no_ram_rd got %0d exp %0d", rd_cnt, rdb); end
    ram_stall = 1'b0;
    n = 0;
    cyc();
    @(negedge clk);
    while (up_stall && n < 40) begin @(negedge clk); n++; end
    checks++; if (up_stall !== 1'b0) begin errors++; $display("FAIL fwd_partial_timeout got %b exp 0", up_stall); end
    checks++; if (up_data_o !== 32'h99885555) begin errors++; $display("FAIL fwd_partial_data got %h exp 99885555", up_data_o); end
    checks++; if (ram_rd !== 1'b1) begin errors++; $display("FAIL fwd_partial_ram_rd got %b exp 1", ram_rd); end
    cyc();
    up_rd = 1'b0;
    cyc();
  endtask
`endif

  task automatic test_reset_mid;
    int base;
    base = wlog_a.size();
    ram_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      up_wr = 1'b1; up_address = 24'h000500 + 24'(4 * k); up_data_i = 32'hA0 + 32'(k); up_data_enable = 4'hF;
      cyc();
    end
    up_wr = 1'b0;
    @(negedge clk);
    checks++; if (ram_wr !== 1'b1 || wbuf_empty !== 1'b0) begin
      errors++; $display("FAIL rmid_busy got wr=%b empty=%b exp 1/0", ram_wr, wbuf_empty); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL rmid_ram_wr got %b exp 0", ram_wr); end
    checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got %b exp 1", wbuf_empty); end
    rst_n = 1'b1;
    ram_stall = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (wlog_a.size() !== base) begin errors++; $display("FAIL rmid_lost_writes got %0d exp %0d", wlog_a.size(), base); end
    checks++; if (ram_wr !== 1'b0) begin errors++; $display("FAIL rmid_idle_wr got %b exp 0", ram_wr); end
    cyc();
  endtask

  task automatic test_wrap;
    logic [AW-1:0] ea [20];
    logic [31:0]   ed [20];
    int base, n, guard;
    base = wlog_a.size();
    for (int i = 0; i < 20; i++) begin
      ea[i] = 24'h000600 + 24'(4 * i);
      ed[i] = $urandom;
    end
    n = 0; guard = 0;
    while (n < 20 && guard < 400) begin
      up_wr = 1'b1; up_address = ea[n]; up_data_i = ed[n]; up_data_enable = 4'hF;
      ram_stall = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (!up_stall) n++;
      guard++;
      cyc();
    end
    up_wr = 1'b0;
    checks++; if (n !== 20) begin errors++; $display("FAIL wrap_accept got %0d exp 20", n); end
    ram_stall = 1'b0;
    guard = 0;
    @(negedge clk);
    while (!wbuf_empty && guard < 40) begin @(negedge clk); guard++; end
    checks++; if (wbuf_empty !== 1'b1) begin errors++; $display("FAIL wrap_drain_timeout got %b exp 1", wbuf_empty); end
    checks++; if (occ_err !== 1'b0) begin errors++; $display("FAIL wrap_occupancy got %b exp 0", occ_err); end
    checks++;
    if (wlog_a.size() !== base + 20) begin
      errors++; $display("FAIL wrap_write_count got %0d exp %0d", wlog_a.size(), base + 20);
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (wlog_a[base+i] !== ea[i] || wlog_d[base+i] !== ed[i] || mem[ea[i][11:2]] !== ed[i]) begin
          errors++; $display("FAIL wrap_entry%0d got %h/%h mem %h exp %h/%h", i, wlog_a[base+i],
                             wlog_d[base+i], mem[ea[i][11:2]], ea[i], ed[i]);
        end
      end
    end
    cyc();
  endtask

  initial begin
    rst_n = 1'b0; up_address = '0; up_data_i = '0; up_data_enable = '0;
    up_rd = 1'b0; up_wr = 1'b0; ram_stall = 1'b0;
    repeat (3) @(posedge clk);
    test_reset();
    rst_n = 1'b1;
    cyc();
    test_single_store();
    test_load_empty();
    test_full();
`ifndef DBUS_WBUF_FORWARD_EN
    test_load_after_store();
`else
    test_forward();
`endif
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
